// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: owns the single main-memory port on behalf of the I-cache
// (block fills), the D-cache (repair reads) and the D-cache writeback path
// (dirty evictions). Only one memory transaction is in flight at a time.
//
// Ports
//   clk_i, rst_ni          clock, async active-low reset
//   ic_req_* / ic_resp_*   I-cache read request (vld/addr/rdy) and return (vld/data)
//   dc_req_* / dc_resp_*   D-cache read request and return
//   dc_wb_*                D-cache writeback (vld/addr/data/rdy), one-entry buffer
//   mem_req_* / mem_resp_* memory request (vld/we/addr/data/rdy) and read return
//   busy_o                 FSM not idle or writeback buffer occupied
//
// Configuration
//   MEM_ARB_RR_EN defined   : I/D reads alternate round-robin (1-bit pointer)
//   MEM_ARB_RR_EN undefined : D-cache reads always beat I-cache reads
module mem_port_arbiter #(
  parameter int CACHE_BLOCK_SIZE = 128
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        ic_req_vld_i,
  input  logic [31:0]                 ic_req_addr_i,
  output logic                        ic_req_rdy_o,
  output logic                        ic_resp_vld_o,
  output logic [CACHE_BLOCK_SIZE-1:0] ic_resp_data_o,
  input  logic                        dc_req_vld_i,
  input  logic [31:0]                 dc_req_addr_i,
  output logic                        dc_req_rdy_o,
  output logic                        dc_resp_vld_o,
  output logic [CACHE_BLOCK_SIZE-1:0] dc_resp_data_o,
  input  logic                        dc_wb_vld_i,
  input  logic [31:0]                 dc_wb_addr_i,
  input  logic [CACHE_BLOCK_SIZE-1:0] dc_wb_data_i,
  output logic                        dc_wb_rdy_o,
  output logic                        mem_req_vld_o,
  output logic                        mem_req_we_o,
  output logic [31:0]                 mem_req_addr_o,
  output logic [CACHE_BLOCK_SIZE-1:0] mem_req_data_o,
  input  logic                        mem_req_rdy_i,
  input  logic                        mem_resp_vld_i,
  input  logic [CACHE_BLOCK_SIZE-1:0] mem_resp_data_i,
  output logic                        busy_o
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP} state_t;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef struct packed {
    logic                        we;
    logic                        own;
    logic [31:0]                 addr;
    logic [CACHE_BLOCK_SIZE-1:0] data;
  } mreq_t;

  state_t                      state;
  mreq_t                       req_q;
  logic                        wb_buf_vld;
  logic [31:0]                 wb_addr;
  logic [CACHE_BLOCK_SIZE-1:0] wb_data;

  logic rd_ok, dc_wins, gnt_wb, gnt_dc, gnt_ic;

`ifdef MEM_ARB_RR_EN
  // rr_dc=1: the D-cache wins a tie; flips to the loser after every read grant
  logic rr_dc;
  assign dc_wins = dc_req_vld_i && (!ic_req_vld_i || rr_dc);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     rr_dc <= 1'b1;
    else if (gnt_dc) rr_dc <= 1'b0;
    else if (gnt_ic) rr_dc <= 1'b1;
  end
`else
  assign dc_wins = dc_req_vld_i;
`endif

  // A buffered writeback always goes first, so no read granted after the
  // eviction was accepted can overtake it.
  assign gnt_wb = (state == IDLE) && wb_buf_vld;
  assign rd_ok  = (state == IDLE) && !wb_buf_vld;
  assign gnt_dc = rd_ok && dc_wins;
  assign gnt_ic = rd_ok && ic_req_vld_i && !dc_wins;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      req_q      <= '0;
      wb_buf_vld <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
    end else begin
      // capture and drain are mutually exclusive: capture needs the buffer empty
      if (dc_wb_vld_i && !wb_buf_vld) begin
        wb_buf_vld <= 1'b1;
        wb_addr    <= dc_wb_addr_i;
        wb_data    <= dc_wb_data_i;
      end else if (gnt_wb) begin
        wb_buf_vld <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (gnt_wb) begin
            req_q.we   <= 1'b1;
            req_q.own  <= OWN_DC;
            req_q.addr <= wb_addr;
            req_q.data <= wb_data;
            state      <= SEND;
          end else if (gnt_dc) begin
            req_q.we   <= 1'b0;
            req_q.own  <= OWN_DC;
            req_q.addr <= dc_req_addr_i;
            req_q.data <= '0;
            state      <= SEND;
          end else if (gnt_ic) begin
            req_q.we   <= 1'b0;
            req_q.own  <= OWN_IC;
            req_q.addr <= ic_req_addr_i;
            req_q.data <= '0;
            state      <= SEND;
          end
        end
        SEND:      if (mem_req_rdy_i) state <= req_q.we ? IDLE : WAIT_RESP;
        WAIT_RESP: if (mem_resp_vld_i) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign ic_req_rdy_o   = gnt_ic;
  assign dc_req_rdy_o   = gnt_dc;
  assign dc_wb_rdy_o    = !wb_buf_vld;

  assign mem_req_vld_o  = (state == SEND);
  assign mem_req_we_o   = req_q.we;
  assign mem_req_addr_o = req_q.addr;
  assign mem_req_data_o = req_q.data;

  // return data is passed straight through; only the owner sees a valid
  assign ic_resp_vld_o  = (state == WAIT_RESP) && mem_resp_vld_i && (req_q.own == OWN_IC);
  assign dc_resp_vld_o  = (state == WAIT_RESP) && mem_resp_vld_i && (req_q.own == OWN_DC);
  assign ic_resp_data_o = mem_resp_data_i;
  assign dc_resp_data_o = mem_resp_data_i;

  assign busy_o = (state != IDLE) || wb_buf_vld;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001: Parameter CACHE_BLOCK_SIZE, default 128, sets the block width in bits for all data ports.
REQ-002: clk_i  in  1  single clock; all logic rising-edge.
REQ-003: rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-004: ic_req_vld_i / ic_req_addr_i / ic_req_rdy_o  in/in/out  1/32/1  I-cache block-fill read request.
REQ-005: ic_resp_vld_o / ic_resp_data_o  out/out  1/CACHE_BLOCK_SIZE  I-cache fill return.
REQ-006: dc_req_vld_i / dc_req_addr_i / dc_req_rdy_o  in/in/out  1/32/1  D-cache repair read request.
REQ-007: dc_resp_vld_o / dc_resp_data_o  out/out  1/CACHE_BLOCK_SIZE  D-cache repair return.
REQ-008: dc_wb_vld_i / dc_wb_addr_i / dc_wb_data_i / dc_wb_rdy_o  in/in/in/out  1/32/CACHE_BLOCK_SIZE/1  D-cache dirty-eviction writeback.
REQ-009: mem_req_vld_o / mem_req_we_o / mem_req_addr_o / mem_req_data_o  out  1/1/32/CACHE_BLOCK_SIZE  main-memory request; we=1 write.
REQ-010: mem_req_rdy_i  in  1  memory accepts request when high with mem_req_vld_o.
REQ-011: mem_resp_vld_i / mem_resp_data_i  in  1/CACHE_BLOCK_SIZE  read data, one pulse per read, in order.
REQ-012: busy_o  out  1  high whenever the state is not IDLE or the writeback buffer is valid.

Function
REQ-013: The block shall own the one memory port, with at most one transaction outstanding at a time.
REQ-014: FSM states: IDLE, SEND, WAIT_RESP.
REQ-015: The writeback buffer is one entry; dc_wb_rdy_o = !wb_buf_vld; on dc_wb_vld_i && dc_wb_rdy_o it captures address and data, and the buffer sets the next cycle.
REQ-016: In IDLE, grant priority is writeback buffer > reads, arbitrated per REQ-029/030; grant latches addr/data/we/owner into request registers and moves the FSM to SEND.
REQ-017: A read grant pulses the matching *_req_rdy_o in the grant cycle (combinational, IDLE only); rdy is 0 in all other states.
REQ-018: A writeback grant clears wb_buf_vld the next cycle, so dc_wb_rdy_o is high in SEND.
REQ-019: In SEND, mem_req_vld_o=1 with registered fields, held stable until mem_req_rdy_i; on handshake: write -> IDLE, read -> WAIT_RESP.
REQ-020: In WAIT_RESP, mem_resp_vld_i shall drive the owner's *_resp_vld_o in the same cycle with data passed through, then the FSM goes to IDLE; the other requester's resp_vld stays 0.
REQ-021: mem_resp_vld_i outside WAIT_RESP shall be ignored.
REQ-022: A writeback arriving in the same cycle as an IDLE read grant is buffered; the read proceeds first.
REQ-023: A buffered writeback is always issued before any read granted after it was buffered, so a repair read never overtakes an older eviction.
REQ-024: Minimum read latency: grant cycle N, mem_req_vld_o at N+1, resp_vld_o at the earliest mem_resp_vld_i cycle >= N+2.

Reset
REQ-025: Reset values: FSM=IDLE, wb_buf_vld=0, request registers=0, rr pointer=D-cache, and all *_vld_o/*_rdy_o=0 except dc_wb_rdy_o=1.
REQ-026: Reset mid-transaction abandons the transaction: no resp pulse is produced and a late mem_resp_vld_i is ignored per REQ-021.
REQ-027: Buffered writeback data is discarded on reset.

Configuration
REQ-028: Macro MEM_ARB_RR_EN selects the read arbitration policy.
REQ-029: Defined: I-cache and D-cache reads alternate round-robin; a 1-bit pointer flips to the other requester after each read grant; the pointer requester wins ties.
REQ-030: Undefined: fixed priority, D-cache read always beats I-cache read; no pointer state.

Verification
REQ-031: Idle, dc_req addr 0x1000, mem_req_rdy_i=1, response 3 cycles later with 0xA5.. -> dc_req_rdy_o at N, mem_req_vld_o/we=0/addr 0x1000 at N+1, dc_resp_vld_o one cycle with 0xA5.., ic_resp_vld_o=0.
REQ-032: wb 0x2000 buffered, then dc_req 0x2000 -> write (we=1, addr 0x2000) issued first and completes, then the read is issued; dc_wb_rdy_o is low only while the buffer holds the entry.
REQ-033: ic and dc reads held continuously for 4 grants -> with MEM_ARB_RR_EN order is D,I,D,I; without it, D,D,D,D and I never granted.
REQ-034: mem_req_rdy_i held low for 5 cycles in SEND -> mem_req_vld_o and address/data stable all 5 cycles; no *_req_rdy_o pulses.
REQ-035: rst_ni asserted in WAIT_RESP, mem_resp_vld_i arrives after release -> no resp_vld_o pulse, FSM in IDLE, dc_wb_rdy_o=1.
